rect_fill_engine: RTL and testbench

Parametrised rectangle fill engine for the VGA pixel-plot path. It supersedes the fixed full-screen black fill: one go pulse fills an arbitrary clipped rectangle with any colour, one pixel per clock. It drives x/y/colour/plot to the VGA adapter and uses a go/busy/done handshake toward the game-control FSM. An abort input stops a fill part-way.

---
 rtl/rect_fill_pkg.sv | 26 ++
 rtl/rect_fill_engine_if.sv | 31 +++
 rtl/rect_fill_engine_xy_scan_counter.sv | 62 ++++++
 rtl/rect_fill_engine.sv | 126 ++++++++++++
 tb/tb_rect_fill_engine.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/rect_fill_pkg.sv
// Shared definitions for the VGA draw engines: screen defaults, fill FSM states
// and the clipping helper.
package rect_fill_pkg;

  localparam int unsigned SCREEN_W_DEF = 320;
  localparam int unsigned SCREEN_H_DEF = 240;
  localparam int unsigned X_W_DEF      = 9;
  localparam int unsigned Y_W_DEF      = 8;
  localparam int unsigned COLOR_W_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } fill_state_e;

  // Extent of a span starting at 'start' of length 'len', clipped to [0, lim).
  function automatic int unsigned clip_extent(input int unsigned start,
                                              input int unsigned len,
                                              input int unsigned lim);
    if (start >= lim) return 0;
    return (len < (lim - start)) ? len : (lim - start);
  endfunction

endpackage

// File: rtl/rect_fill_engine_if.sv
// Fill request / pixel-plot bundle between the game-control FSM (master)
// and the rectangle fill engine (slave).
interface rect_fill_engine_if #(
  parameter int unsigned X_W     = 9,
  parameter int unsigned Y_W     = 8,
  parameter int unsigned COLOR_W = 3
);
  logic               go;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [X_W-1:0]     rect_w;
  logic [Y_W-1:0]     rect_h;
  logic [COLOR_W-1:0] fill_color;
  logic               abort;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] color;
  logic               plot;
  logic               busy;
  logic               done;

  modport master (
    output go, x0, y0, rect_w, rect_h, fill_color, abort,
    input  x, y, color, plot, busy, done
  );

  modport slave (
    input  go, x0, y0, rect_w, rect_h, fill_color, abort,
    output x, y, color, plot, busy, done
  );
endinterface

// File: rtl/rect_fill_engine_xy_scan_counter.sv
// Raster scan counter: walks (cx, cy) across a clipped rectangle, one step per
// enabled cycle, and flags the bottom-right pixel.
module xy_scan_counter #(
  parameter int unsigned X_W = 9,
  parameter int unsigned Y_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_i,
  input  logic [X_W-1:0] x_start_i,
  input  logic [Y_W-1:0] y_start_i,
  input  logic [X_W-1:0] ew_i,
  input  logic [Y_W-1:0] eh_i,
  input  logic           step_i,
  output logic [X_W-1:0] cx_o,
  output logic [Y_W-1:0] cy_o,
  output logic           last_o
);

  logic [X_W-1:0] cx_q, cx_d, x_start_q, x_end_q;
  logic [Y_W-1:0] cy_q, cy_d, y_end_q;

  // End coordinates are inclusive; load only happens with non-zero extents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx_q      <= '0;
      cy_q      <= '0;
      x_start_q <= '0;
      x_end_q   <= '0;
      y_end_q   <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
      if (load_i) begin
        x_start_q <= x_start_i;
        x_end_q   <= X_W'(x_start_i + ew_i - X_W'(1));
        y_end_q   <= Y_W'(y_start_i + eh_i - Y_W'(1));
      end
    end
  end

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (load_i) begin
      cx_d = x_start_i;
      cy_d = y_start_i;
    end else if (step_i) begin
      if (cx_q == x_end_q) begin
        cx_d = x_start_q;
        cy_d = cy_q + Y_W'(1);
      end else begin
        cx_d = cx_q + X_W'(1);
      end
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = (cx_q == x_end_q) && (cy_q == y_end_q);

endmodule

// File: rtl/rect_fill_engine.sv
// Clipped rectangle fill for the VGA plot path: one pixel per clock after a
// go pulse, with go/busy/done handshake and abort.
module rect_fill_engine
  import rect_fill_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned X_W      = X_W_DEF,
  parameter int unsigned Y_W      = Y_W_DEF,
  parameter int unsigned COLOR_W  = COLOR_W_DEF
) (
  input logic               clk,
  input logic               reset,
  rect_fill_engine_if.slave bus
);

  fill_state_e        state_q, state_d;
  logic [X_W-1:0]     x0_q, w_q, ew_c, cx;
  logic [Y_W-1:0]     y0_q, h_q, eh_c, cy;
  logic [COLOR_W-1:0] col_q, color_q, color_d;
  logic               plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic               latch_c, load_c, step_c, last_c;

  // Clipped extents from the request captured at go.
  assign ew_c = X_W'(clip_extent(32'(x0_q), 32'(w_q), SCREEN_W));
  assign eh_c = Y_W'(clip_extent(32'(y0_q), 32'(h_q), SCREEN_H));

  xy_scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_scan (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load_c),
    .x_start_i (x0_q),
    .y_start_i (y0_q),
    .ew_i      (ew_c),
    .eh_i      (eh_c),
    .step_i    (step_c),
    .cx_o      (cx),
    .cy_o      (cy),
    .last_o    (last_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      color_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (latch_c) begin
        x0_q  <= bus.x0;
        y0_q  <= bus.y0;
        w_q   <= bus.rect_w;
        h_q   <= bus.rect_h;
        col_q <= bus.fill_color;
      end
    end
  end

  // Output flops are loaded with the values belonging to the next state.
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    plot_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    latch_c = 1'b0;
    load_c  = 1'b0;
    step_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          latch_c = 1'b1;
          state_d = ST_LOAD;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if ((ew_c == '0) || (eh_c == '0)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          load_c  = 1'b1;
          state_d = ST_FILL;
          plot_d  = 1'b1;
          busy_d  = 1'b1;
          color_d = col_q;
        end
      end
      ST_FILL: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (last_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          step_c = 1'b1;
          plot_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.x     = cx;
  assign bus.y     = cy;
  assign bus.color = color_q;
  assign bus.plot  = plot_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed and randomized fills checked cycle by cycle against a raster model
// built from the clipped rectangle arithmetic.
module tb_rect_fill_engine;

  localparam int unsigned SW = 320;
  localparam int unsigned SH = 240;
  localparam int unsigned XW = 9;
  localparam int unsigned YW = 8;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  rect_fill_engine_if #(.X_W(XW), .Y_W(YW), .COLOR_W(CW)) bus ();

  rect_fill_engine #(
    .SCREEN_W(SW), .SCREEN_H(SH), .X_W(XW), .Y_W(YW), .COLOR_W(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_extent(input int o, input int len, input int lim);
    if (o >= lim) return 0;
    return (len < lim - o) ? len : lim - o;
  endfunction

  function automatic logic [2:0] hs();
    return {bus.busy, bus.plot, bus.done};
  endfunction

  // One complete request; abort_at is a 0-based pixel index or -1.
  task automatic run_fill(input int x0, input int y0, input int w, input int h, input int col,
                          input int abort_at, input bit poke_go, input bit with_abort);
    int    ew, eh, p, bad, ex, ey;
    string first;
    logic  quiet;
    ew = ref_extent(x0, w, SW);
    eh = ref_extent(y0, h, SH);
    p = ew * eh;
    bad = 0;
    first = "none";
    @(negedge clk);
    bus.x0 = XW'(x0); bus.y0 = YW'(y0);
    bus.rect_w = XW'(w); bus.rect_h = YW'(h);
    bus.fill_color = CW'(col);
    bus.go = 1'b1; bus.abort = with_abort;
    @(posedge clk); #1;
    bus.go = 1'b0; bus.abort = 1'b0;
    bus.x0 = XW'($urandom); bus.y0 = YW'($urandom);
    bus.rect_w = XW'($urandom); bus.rect_h = YW'($urandom);
    bus.fill_color = CW'($urandom);
    @(negedge clk);
    chk($sformatf("load_phase(%0d,%0d)", x0, y0), 32'(hs()), 32'(3'b100));
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      bus.go = 1'b0;
      ex = x0 + i % ew;
      ey = y0 + i / ew;
      if (bus.plot !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
          bus.x !== XW'(ex) || bus.y !== YW'(ey) || bus.color !== CW'(col)) begin
        if (bad == 0)
          first = $sformatf("pix%0d got(%0d,%0d,c%0d,hs%b) want(%0d,%0d,c%0d,hs110)",
                            i, bus.x, bus.y, bus.color, hs(), ex, ey, col);
        bad++;
      end
      if (i == abort_at) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk($sformatf("pixels_before_abort %s", first), 32'(bad), 32'd0);
        chk("abort_next_cycle", 32'(hs()), 32'd0);
        quiet = 1'b0;
        repeat (3) begin
          @(negedge clk);
          quiet = quiet | bus.done | bus.busy | bus.plot;
        end
        chk("abort_no_done", 32'(quiet), 32'd0);
        return;
      end
      if (poke_go && i == p / 2) bus.go = 1'b1;
    end
    chk($sformatf("pixels(%0d,%0d,%0dx%0d) %s", x0, y0, w, h, first), 32'(bad), 32'd0);
    @(negedge clk);
    bus.go = poke_go;
    chk("done_pulse", 32'(hs()), 32'(3'b001));
    @(negedge clk);
    bus.go = 1'b0;
    chk("after_done", 32'(hs()), 32'd0);
    @(negedge clk);
    chk("idle_after", 32'(hs()), 32'd0);
  endtask

  initial begin
    logic quiet;
    int   rx, ry, rw, rh, ab;
    reset = 1'b1;
    bus.go = 1'b0; bus.abort = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.rect_w = '0; bus.rect_h = '0; bus.fill_color = '0;
    #12;
    chk("reset_values", 32'({bus.x, bus.y, bus.color, bus.plot, bus.busy, bus.done}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_fill(10, 20, 3, 2, 5, -1, 1'b0, 1'b0);
    run_fill(318, 238, 5, 5, 6, -1, 1'b0, 1'b0);
    run_fill(40, 30, 0, 7, 3, -1, 1'b0, 1'b0);
    run_fill(320, 5, 4, 4, 2, -1, 1'b0, 1'b0);
    run_fill(7, 240, 4, 4, 2, -1, 1'b0, 1'b0);
    run_fill(60, 70, 10, 10, 4, 4, 1'b0, 1'b0);
    run_fill(5, 5, 10, 10, 1, -1, 1'b0, 1'b0);
    run_fill(100, 100, 4, 3, 7, -1, 1'b0, 1'b1);
    run_fill(200, 100, 7, 5, 3, -1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a fill.
    @(negedge clk);
    bus.x0 = XW'(50); bus.y0 = YW'(50); bus.rect_w = XW'(10); bus.rect_h = YW'(10);
    bus.fill_color = CW'(7); bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pre_reset_plot", 32'(bus.plot), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({bus.x, bus.y, bus.color, bus.plot, bus.busy, bus.done}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b0;
    repeat (4) begin
      @(negedge clk);
      quiet = quiet | bus.done | bus.busy | bus.plot;
    end
    chk("post_reset_quiet", 32'(quiet), 32'd0);

    for (int k = 0; k < 24; k++) begin
      rx = int'($urandom_range(0, 330));
      ry = int'($urandom_range(0, 250));
      rw = int'($urandom_range(0, 12));
      rh = int'($urandom_range(0, 9));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_fill(rx, ry, rw, rh, int'($urandom_range(0, 7)), ab,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    run_fill(0, 0, 320, 240, 0, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
